// File: rtl/cbfp_pkg.sv
// Shared definitions for the block-floating-point normalizer: default widths,
// the zero-shift reference count, the ping-pong bank state and output saturation.
package cbfp_pkg;

    localparam int DEF_IN_WIDTH    = 23;
    localparam int DEF_OUT_WIDTH   = 11;
    localparam int DEF_DATA_NUM    = 16;
    localparam int DEF_BLK_BEATS   = 4;
    localparam int DEF_SHIFT_WIDTH = 5;
    localparam int DEF_REF_SHIFT   = 12;

    // Working width for shifted samples; must exceed IN_WIDTH + 1.
    localparam int CALC_W = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    function automatic logic signed [CALC_W-1:0] saturate(
        input logic signed [CALC_W-1:0] v,
        input int                       w
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cbfp_lsc.sv
// Leading-sign count of one signed sample: how many bits below the MSB repeat it.
// Zero and -1 both yield IN_WIDTH-1.
module cbfp_lsc
    import cbfp_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic [IN_WIDTH-1:0]    i_data,
    output logic [SHIFT_WIDTH-1:0] o_lsc
);

    logic w_stop;

    always_comb begin
        o_lsc  = '0;
        w_stop = 1'b0;
        for (int i = IN_WIDTH - 2; i >= 0; i--) begin
            if (!w_stop && (i_data[i] == i_data[IN_WIDTH-1]))
                o_lsc = o_lsc + SHIFT_WIDTH'(1);
            else
                w_stop = 1'b1;
        end
    end

endmodule

// File: rtl/cbfp_block_norm.sv
// Convergent block-floating-point normalizer with ping-pong block buffering.
// Optional macro CBFP_ROUND_EN: round-half-up on right shifts instead of truncation.
module cbfp_block_norm
    import cbfp_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int DATA_NUM    = DEF_DATA_NUM,
    parameter int BLK_BEATS   = DEF_BLK_BEATS,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int REF_SHIFT   = DEF_REF_SHIFT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_NUM-1:0][IN_WIDTH-1:0]   in_real,
    input  logic [DATA_NUM-1:0][IN_WIDTH-1:0]   in_imag,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_NUM-1:0][OUT_WIDTH-1:0]  out_real,
    output logic [DATA_NUM-1:0][OUT_WIDTH-1:0]  out_imag,
    output logic signed [SHIFT_WIDTH:0]         out_exp,
    output logic                                out_last
);

    localparam int                     PTR_W    = $clog2(BLK_BEATS);
    localparam logic [SHIFT_WIDTH-1:0] MAX_LSC  = SHIFT_WIDTH'(IN_WIDTH - 1);
    localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(BLK_BEATS - 1);

    logic [IN_WIDTH-1:0]        r_mem_re [2][BLK_BEATS][DATA_NUM];
    logic [IN_WIDTH-1:0]        r_mem_im [2][BLK_BEATS][DATA_NUM];
    bank_state_e                r_state     [2];
    bank_state_e                w_state_nxt [2];
    logic signed [SHIFT_WIDTH:0] r_exp [2];

    logic                       r_wbank;
    logic                       r_rbank;
    logic                       w_wbank_nxt;
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [SHIFT_WIDTH-1:0]     r_run_min;
    logic [SHIFT_WIDTH-1:0]     w_beat_min;
    logic [SHIFT_WIDTH-1:0]     w_new_min;
    logic [SHIFT_WIDTH-1:0]     w_lsc_re [DATA_NUM];
    logic [SHIFT_WIDTH-1:0]     w_lsc_im [DATA_NUM];
    logic                       r_in_ready;
    logic                       w_in_ready_nxt;
    logic                       w_acc;
    logic                       w_xfer;
    logic                       w_wlast;
    logic                       w_rlast;

    // Shift one sample by the block exponent (positive = right), then clamp.
    function automatic logic [OUT_WIDTH-1:0] norm(
        input logic [IN_WIDTH-1:0]         x,
        input logic signed [SHIFT_WIDTH:0] e
    );
        logic signed [CALC_W-1:0] v;
        int                       sh;
        v  = {{(CALC_W - IN_WIDTH){x[IN_WIDTH-1]}}, x};
        sh = int'(e);
        if (sh < 0) begin
            v = v <<< (-sh);
        end else begin
`ifdef CBFP_ROUND_EN
            if (sh > 0) v = v + (32'sd1 <<< (sh - 1));
`endif
            v = v >>> sh;
        end
        v = saturate(v, OUT_WIDTH);
        return v[OUT_WIDTH-1:0];
    endfunction

    for (genvar g = 0; g < DATA_NUM; g++) begin : g_lsc
        cbfp_lsc #(.IN_WIDTH(IN_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)) u_lsc_re (
            .i_data (in_real[g]),
            .o_lsc  (w_lsc_re[g])
        );
        cbfp_lsc #(.IN_WIDTH(IN_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)) u_lsc_im (
            .i_data (in_imag[g]),
            .o_lsc  (w_lsc_im[g])
        );
    end

    assign w_acc     = in_valid && r_in_ready;
    assign w_xfer    = out_valid && out_ready;
    assign w_wlast   = (r_wptr == LAST_PTR);
    assign w_rlast   = (r_rptr == LAST_PTR);
    assign in_ready  = r_in_ready;
    assign out_valid = (r_state[r_rbank] == BANK_FULL) || (r_state[r_rbank] == BANK_DRAINING);

    always_comb begin
        w_beat_min = MAX_LSC;
        for (int i = 0; i < DATA_NUM; i++) begin
            if (w_lsc_re[i] < w_beat_min) w_beat_min = w_lsc_re[i];
            if (w_lsc_im[i] < w_beat_min) w_beat_min = w_lsc_im[i];
        end
        w_new_min = (w_beat_min < r_run_min) ? w_beat_min : r_run_min;
    end

    // The write and read banks are never the same bank while both handshakes fire,
    // so the two updates below cannot collide. in_ready looks one edge ahead.
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc)
            w_state_nxt[r_wbank] = w_wlast ? BANK_FULL : BANK_FILLING;
        if (w_xfer)
            w_state_nxt[r_rbank] = w_rlast ? BANK_EMPTY : BANK_DRAINING;
        w_wbank_nxt    = r_wbank ^ (w_acc && w_wlast);
        w_in_ready_nxt = (w_state_nxt[w_wbank_nxt] == BANK_EMPTY) ||
                         (w_state_nxt[w_wbank_nxt] == BANK_FILLING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_exp[0]   <= '0;
            r_exp[1]   <= '0;
            r_wbank    <= 1'b0;
            r_rbank    <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_run_min  <= MAX_LSC;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_in_ready_nxt;
            if (w_acc) begin
                r_wptr <= r_wptr + PTR_W'(1);
                if (w_wlast) begin
                    r_wbank        <= ~r_wbank;
                    r_exp[r_wbank] <= $signed((SHIFT_WIDTH + 1)'(REF_SHIFT)) - $signed({1'b0, w_new_min});
                    r_run_min      <= MAX_LSC;
                end else begin
                    r_run_min <= w_new_min;
                end
            end
            if (w_xfer) begin
                r_rptr <= r_rptr + PTR_W'(1);
                if (w_rlast) r_rbank <= ~r_rbank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int i = 0; i < DATA_NUM; i++) begin
                r_mem_re[r_wbank][r_wptr][i] <= in_real[i];
                r_mem_im[r_wbank][r_wptr][i] <= in_imag[i];
            end
        end
    end

    // Outputs are held at zero whenever no beat is presented.
    always_comb begin
        out_real = '0;
        out_imag = '0;
        out_exp  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            for (int i = 0; i < DATA_NUM; i++) begin
                out_real[i] = norm(r_mem_re[r_rbank][r_rptr][i], r_exp[r_rbank]);
                out_imag[i] = norm(r_mem_im[r_rbank][r_rptr][i], r_exp[r_rbank]);
            end
            out_exp  = r_exp[r_rbank];
            out_last = w_rlast;
        end
    end

endmodule

// File: tb/tb_cbfp_block_norm.sv
// Scoreboard bench for cbfp_block_norm: directed blocks with hand-derived outputs.
module tb_cbfp_block_norm;

    localparam int IW = 23;
    localparam int OW = 11;
    localparam int DN = 16;
    localparam int BB = 4;
    localparam int SW = 5;

    localparam int K_PEAK = 0;
    localparam int K_ZERO = 1;
    localparam int K_NEG1 = 2;
    localparam int K_SAT  = 3;
    localparam int K_LEFT = 4;
    localparam int K_BIG  = 5;
    localparam int K_SEQ  = 6;

`ifdef CBFP_ROUND_EN
    localparam int RND_5 = 1;
`else
    localparam int RND_5 = 0;
`endif

    typedef struct packed {
        logic [DN-1:0][OW-1:0] re;
        logic [DN-1:0][OW-1:0] im;
        logic signed [SW:0]    ex;
        logic                  last;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [DN-1:0][IW-1:0] in_real;
    logic [DN-1:0][IW-1:0] in_imag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DN-1:0][OW-1:0] out_real;
    logic [DN-1:0][OW-1:0] out_imag;
    logic signed [SW:0]    out_exp;
    logic                  out_last;

    exp_t q[$];
    int   tests;
    int   fails;

    cbfp_block_norm dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_exp   (out_exp),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int stim(input int k, input int b, input int l, input bit im);
        case (k)
            K_PEAK:  return (!im && b == 0 && l == 0) ? 4096 : ((!im && b == 0 && l == 1) ? 5 : 0);
            K_ZERO:  return 0;
            K_NEG1:  return -1;
            K_SAT:   return (im && b == 1 && l == 3) ? 8191 : 0;
            K_LEFT:  return (!im && b == 2 && l == 7) ? -3 : 5;
            K_BIG: begin
                if (!im && b == 3 && l == 0) return 2097152;
                if (im && b == 0 && l == 2) return -4194304;
                return (l % 2 == 1) ? 8192 : -8192;
            end
            default: return im ? -((b * 16 + l + 1) * 64) : (b * 16 + l + 1) * 64;
        endcase
    endfunction

    function automatic int expv(input int k, input int b, input int l, input bit im);
        case (k)
            K_PEAK:  return (!im && b == 0 && l == 0) ? 512 : ((!im && b == 0 && l == 1) ? RND_5 : 0);
            K_ZERO:  return 0;
            K_NEG1:  return -1024;
            K_SAT:   return (im && b == 1 && l == 3) ? 1023 : 0;
            K_LEFT:  return (!im && b == 2 && l == 7) ? -384 : 640;
            K_BIG: begin
                if (!im && b == 3 && l == 0) return 512;
                if (im && b == 0 && l == 2) return -1024;
                return (l % 2 == 1) ? 2 : -2;
            end
            default: return im ? -((b * 16 + l + 1) * 8) : (b * 16 + l + 1) * 8;
        endcase
    endfunction

    function automatic int expx(input int k);
        case (k)
            K_ZERO, K_NEG1: return -10;
            K_LEFT:         return -7;
            K_BIG:          return 12;
            default:        return 3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send_beat(input int k, input int b);
        exp_t e;
        int   n;
        bit   acc;
        for (int l = 0; l < DN; l++) begin
            in_real[l] = IW'(stim(k, b, l, 1'b0));
            in_imag[l] = IW'(stim(k, b, l, 1'b1));
            e.re[l]    = OW'(expv(k, b, l, 1'b0));
            e.im[l]    = OW'(expv(k, b, l, 1'b1));
        end
        e.ex     = (SW + 1)'(expx(k));
        e.last   = (b == BB - 1);
        in_valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else n++;
        end
        if (acc) begin
            q.push_back(e);
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: kind %0d beat %0d not accepted, in_ready=%0d required 1", k, b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int k);
        for (int b = 0; b < BB; b++) send_beat(k, b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_beats", q.size(), 0);
        @(posedge clk);
        @(negedge clk);
        check("idle_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        int   bad;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got a beat with exp=%0d, required none", out_exp);
                end else begin
                    e   = q.pop_front();
                    bad = -1;
                    for (int l = DN - 1; l >= 0; l--)
                        if (out_real[l] !== e.re[l] || out_imag[l] !== e.im[l]) bad = l;
                    tests++;
                    if (bad >= 0) begin
                        fails++;
                        $display("FAIL beat_data lane %0d: got re=%0d im=%0d, required re=%0d im=%0d",
                                 bad, $signed(out_real[bad]), $signed(out_imag[bad]),
                                 $signed(e.re[bad]), $signed(e.im[bad]));
                    end
                    check("out_exp", int'(out_exp), int'(e.ex));
                    check("out_last", int'(out_last), int'(e.last));
                end
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_out_exp", int'(out_exp), 0);
        check("reset_out_data_zero", int'(out_real == '0 && out_imag == '0), 1);
        @(posedge clk);
        #1;

        // Single peak block; out_valid must rise right after the final beat.
        send_block(K_PEAK);
        @(negedge clk);
        check("out_valid_rise", int'(out_valid), 1);
        drain();

        // Back-to-back blocks with out_ready held high.
        fork
            begin
                send_block(K_ZERO);
                send_block(K_NEG1);
                send_block(K_SAT);
                send_block(K_LEFT);
            end
            begin
                int n;
                int gaps;
                n    = 0;
                gaps = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                for (int c = 1; c < 4 * BB; c++) begin
                    @(negedge clk);
                    if (!out_valid) gaps++;
                end
                check("stream_valid_gaps", gaps + ((n >= 100) ? 1000 : 0), 0);
            end
        join
        drain();

        // Backpressure: two blocks fill both banks, the third must wait.
        out_ready = 1'b0;
        fork
            begin
                send_block(K_SEQ);
                send_block(K_LEFT);
                send_block(K_BIG);
            end
            begin
                repeat (9) @(posedge clk);
                @(negedge clk);
                check("in_ready_banks_full", int'(in_ready), 0);
                check("out_valid_held", int'(out_valid), 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset after two beats of a block: nothing may come out.
        send_beat(K_LEFT, 0);
        send_beat(K_LEFT, 1);
        rst = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_out_valid", int'(out_valid), 0);
        repeat (5) @(posedge clk);
        #1;
        send_block(K_PEAK);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
